// File: rtl/multicycle_ctrl.sv
// Multicycle instruction-sequencing controller: FETCH/DECODE/EXEC/MEM/WB/TRAP with
// memory-wait timeouts and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [6:0]           opcode,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 trap_clr,
  output logic                 imem_req,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 wb_en,
  output logic [1:0]           wb_sel,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  state_e               r_state;
  logic [7:0]           r_wait;
  logic [CNT_WIDTH-1:0] r_instret;
  logic [1:0]           r_cause;

  logic w_legal;
  logic w_is_load;
  logic w_is_store;
  logic w_is_branch;
  logic w_is_jump;

  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      7'b0110011, 7'b0010011, OpLoad, OpStore, OpBranch,
      OpJal, OpJalr, 7'b0110111, 7'b0010111: w_legal = 1'b1;
      default:                               w_legal = 1'b0;
    endcase
  end

  assign w_is_load   = (opcode == OpLoad);
  assign w_is_store  = (opcode == OpStore);
  assign w_is_branch = (opcode == OpBranch);
  assign w_is_jump   = (opcode == OpJal) || (opcode == OpJalr);

  // Every transition clears r_wait; it only advances while FETCH/MEM stall.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= StFetch;
      r_wait    <= 8'd0;
      r_instret <= '0;
      r_cause   <= 2'b00;
    end else begin
      case (r_state)
        StFetch: begin
          if (imem_ready) begin
            r_state <= StDecode;
            r_wait  <= 8'd0;
          end else if (r_wait == WaitLast) begin
            r_state <= StTrap;
            r_cause <= 2'b10;
            r_wait  <= 8'd0;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        StDecode: begin
          r_wait <= 8'd0;
          if (w_legal) begin
            r_state <= StExec;
          end else begin
            r_state <= StTrap;
            r_cause <= 2'b01;
          end
        end
        StExec: begin
          r_wait <= 8'd0;
          if (w_is_load || w_is_store) begin
            r_state <= StMem;
          end else if (w_is_branch) begin
            r_state   <= StFetch;
            r_instret <= r_instret + CNT_WIDTH'(1);
          end else begin
            r_state <= StWb;
          end
        end
        StMem: begin
          if (dmem_ready) begin
            r_wait <= 8'd0;
            if (w_is_store) begin
              r_state   <= StFetch;
              r_instret <= r_instret + CNT_WIDTH'(1);
            end else begin
              r_state <= StWb;
            end
          end else if (r_wait == WaitLast) begin
            r_state <= StTrap;
            r_cause <= 2'b11;
            r_wait  <= 8'd0;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        StWb: begin
          r_wait    <= 8'd0;
          r_state   <= StFetch;
          r_instret <= r_instret + CNT_WIDTH'(1);
        end
        StTrap: begin
          r_wait <= 8'd0;
          if (trap_clr) begin
            r_state <= StFetch;
            r_cause <= 2'b00;
          end
        end
        default: begin
          r_state <= StFetch;
          r_wait  <= 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    wb_en    = 1'b0;
    wb_sel   = 2'b00;
    trap     = 1'b0;
    case (r_state)
      StFetch: begin
        imem_req = 1'b1;
        // Keep the IR strobe quiet while reset is held.
        ir_we    = imem_ready & arst_n;
      end
      StExec: pc_we = w_is_branch;
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = w_is_store;
        pc_we    = w_is_store & dmem_ready;
      end
      StWb: begin
        wb_en = 1'b1;
        pc_we = 1'b1;
        if (w_is_load) begin
          wb_sel = 2'b01;
        end else if (w_is_jump) begin
          wb_sel = 2'b10;
        end else begin
          wb_sel = 2'b00;
        end
      end
      StTrap: trap = 1'b1;
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  assign instret    = r_instret;
  assign trap_cause = r_cause;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle strobe checks plus a scoreboard of
// expected wb_sel values and retired counts.
module tb_multicycle_ctrl;

  localparam logic [6:0] OpAlu    = 7'b0110011;
  localparam logic [6:0] OpAddi   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBad    = 7'b1111111;

  logic       clk;
  logic       arst_n;
  logic [6:0] opcode;
  logic       imem_ready;
  logic       dmem_ready;
  logic       trap_clr;
  logic       imem_req;
  logic       ir_we;
  logic       pc_we;
  logic       dmem_req;
  logic       dmem_we;
  logic       wb_en;
  logic [1:0] wb_sel;
  logic       trap;
  logic [1:0] trap_cause;
  logic [3:0] instret;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] q_wbsel[$];
  logic [3:0] q_ret[$];
  logic [3:0] m_instret = 4'd0;

  multicycle_ctrl #(
    .CNT_WIDTH(4),
    .TIMEOUT  (16)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .opcode    (opcode),
    .imem_ready(imem_ready),
    .dmem_ready(dmem_ready),
    .trap_clr  (trap_clr),
    .imem_req  (imem_req),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .wb_en     (wb_en),
    .wb_sel    (wb_sel),
    .trap      (trap),
    .trap_cause(trap_cause),
    .instret   (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // wb_sel scoreboard: one expected entry per WB cycle, 00 everywhere else.
  always @(negedge clk) begin
    if (wb_en === 1'b1) begin
      if (q_wbsel.size() == 0) chk("wb_unexpected", 32'(wb_en), 32'd0);
      else chk("wb_sel", 32'(wb_sel), 32'(q_wbsel.pop_front()));
    end else begin
      chk("wb_sel_idle", 32'(wb_sel), 32'd0);
    end
  end

  // Runs one instruction from FETCH with iw imem and dw dmem stall cycles.
  task automatic run_instr(input logic [6:0] op, input int iw, input int dw);
    logic ls;
    logic st;
    logic br;
    ls = (op == OpLoad) || (op == OpStore);
    st = (op == OpStore);
    br = (op == OpBranch);
    if (!(br || st)) begin
      if (op == OpLoad) q_wbsel.push_back(2'b01);
      else if (op == OpJal || op == 7'b1100111) q_wbsel.push_back(2'b10);
      else q_wbsel.push_back(2'b00);
    end
    m_instret = m_instret + 4'd1;
    q_ret.push_back(m_instret);
    opcode = op;
    for (int i = 0; i < iw; i++) begin
      imem_ready = 1'b0;
      #1;
      chk("fetch_wait_req", 32'(imem_req), 32'd1);
      chk("fetch_wait_irwe", 32'(ir_we), 32'd0);
      chk("fetch_wait_trap", 32'(trap), 32'd0);
      cyc();
    end
    imem_ready = 1'b1;
    #1;
    chk("fetch_irwe", 32'(ir_we), 32'd1);
    chk("fetch_req", 32'(imem_req), 32'd1);
    cyc();
    imem_ready = 1'b0;
    #1;
    chk("decode_req", 32'(imem_req), 32'd0);
    chk("decode_pcwe", 32'(pc_we), 32'd0);
    chk("decode_trap", 32'(trap), 32'd0);
    cyc();
    #1;
    chk("exec_pcwe", 32'(pc_we), 32'(br));
    chk("exec_dreq", 32'(dmem_req), 32'd0);
    cyc();
    if (ls) begin
      for (int j = 0; j < dw; j++) begin
        dmem_ready = 1'b0;
        #1;
        chk("mem_wait_req", 32'(dmem_req), 32'd1);
        chk("mem_wait_we", 32'(dmem_we), 32'(st));
        chk("mem_wait_pcwe", 32'(pc_we), 32'd0);
        cyc();
      end
      dmem_ready = 1'b1;
      #1;
      chk("mem_req", 32'(dmem_req), 32'd1);
      chk("mem_pcwe", 32'(pc_we), 32'(st));
      cyc();
      dmem_ready = 1'b0;
    end
    if (!(br || st)) begin
      #1;
      chk("wb_en", 32'(wb_en), 32'd1);
      chk("wb_pcwe", 32'(pc_we), 32'd1);
      chk("wb_instret_before", 32'(instret), 32'(m_instret - 4'd1));
      cyc();
    end
    #1;
    chk("retired_instret", 32'(instret), 32'(q_ret.pop_front()));
    chk("back_in_fetch", 32'(imem_req), 32'd1);
  endtask

  initial begin
    arst_n     = 1'b0;
    opcode     = OpAddi;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    trap_clr   = 1'b0;
    #2;
    chk("rst_imem_req", 32'(imem_req), 32'd1);
    chk("rst_ir_we", 32'(ir_we), 32'd0);
    chk("rst_pc_we", 32'(pc_we), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_cause", 32'(trap_cause), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    cyc();
    cyc();
    arst_n = 1'b1;

    // Legal instruction mix, including stalls on both memories.
    run_instr(OpAddi, 0, 0);
    run_instr(OpLoad, 1, 3);
    run_instr(OpStore, 0, 1);
    run_instr(OpJal, 2, 0);
    run_instr(OpLui, 0, 0);
    run_instr(OpBranch, 0, 0);

    // Illegal opcode traps after DECODE; strobes stay quiet in TRAP.
    opcode     = OpBad;
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      #1;
      chk("illegal_trap", 32'(trap), 32'd1);
      chk("illegal_cause", 32'(trap_cause), 32'd1);
      chk("trap_quiet", 32'({imem_req, ir_we, pc_we, dmem_req, dmem_we, wb_en}), 32'd0);
      cyc();
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    chk("illegal_instret", 32'(instret), 32'(m_instret));
    trap_clr = 1'b1;
    cyc();
    trap_clr = 1'b0;
    #1;
    chk("clr_trap", 32'(trap), 32'd0);
    chk("clr_cause", 32'(trap_cause), 32'd0);
    chk("clr_fetch", 32'(imem_req), 32'd1);

    // imem timeout; trap_clr during FETCH must be ignored.
    for (int i = 0; i < 16; i++) begin
      trap_clr = (i < 3);
      #1;
      chk("ito_wait_trap", 32'(trap), 32'd0);
      chk("ito_wait_req", 32'(imem_req), 32'd1);
      cyc();
    end
    trap_clr = 1'b0;
    #1;
    chk("ito_trap", 32'(trap), 32'd1);
    chk("ito_cause", 32'(trap_cause), 32'd2);
    chk("ito_req", 32'(imem_req), 32'd0);
    cyc();
    #1;
    chk("ito_hold_cause", 32'(trap_cause), 32'd2);
    trap_clr = 1'b1;
    cyc();
    trap_clr = 1'b0;
    #1;
    chk("ito_clr_cause", 32'(trap_cause), 32'd0);

    // Ready on the threshold cycle wins over the timeout.
    run_instr(OpAlu, 15, 0);
    run_instr(OpLoad, 10, 15);

    // dmem timeout on a load.
    opcode     = OpLoad;
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("dto_wait_req", 32'(dmem_req), 32'd1);
      cyc();
    end
    #1;
    chk("dto_trap", 32'(trap), 32'd1);
    chk("dto_cause", 32'(trap_cause), 32'd3);
    chk("dto_instret", 32'(instret), 32'(m_instret));
    trap_clr = 1'b1;
    cyc();
    trap_clr = 1'b0;

    // 16 branches: the 4-bit counter crosses 15 -> 0 exactly once.
    for (int i = 0; i < 16; i++) run_instr(OpBranch, 0, 0);
    run_instr(OpAddi, 0, 0);

    // Reset asserted while a load waits in MEM.
    opcode     = OpLoad;
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    cyc();
    cyc();
    #1;
    chk("mem_before_rst", 32'(dmem_req), 32'd1);
    arst_n = 1'b0;
    #1;
    chk("mrst_dmem_req", 32'(dmem_req), 32'd0);
    chk("mrst_imem_req", 32'(imem_req), 32'd1);
    chk("mrst_instret", 32'(instret), 32'd0);
    cyc();
    arst_n    = 1'b1;
    m_instret = 4'd0;
    run_instr(OpAddi, 0, 0);

    chk("wbsel_queue_empty", 32'(q_wbsel.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
